// File: rtl/sc_window_sng.sv
// ----------------------------------------------------------------------------
// sc_window_sng
//   Deterministic stochastic number generator for one 2x2 pixel window.
//   A captured window is turned into a 2^WIDTH-cycle frame of unary
//   bitstreams. All four pixel streams are compared against one shared ramp
//   counter, so they are maximally positively correlated. This lets a
//   downstream XOR produce |a-b|. The sel stream is the counter LSB, which
//   gives exactly N/2 ones per frame.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   en         : stream enable, 0 stalls the frame in place (ignored in IDLE)
//   in_valid   : window is presented on p00..p11
//   in_ready   : window is accepted this cycle when in_valid is also high
//   p00..p11   : unsigned pixel values, sampled on accept
//   r00..r11   : stochastic bits of the captured pixels
//   sel        : 0.5-probability select stream for the scaled adder
//   bit_valid  : current r*/sel bits belong to a frame
//   done       : final bit cycle of a frame
// ----------------------------------------------------------------------------
module sc_window_sng #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p00,
    input  logic [WIDTH-1:0] p01,
    input  logic [WIDTH-1:0] p10,
    input  logic [WIDTH-1:0] p11,
    output logic             r00,
    output logic             r01,
    output logic             r10,
    output logic             r11,
    output logic             sel,
    output logic             bit_valid,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    // Unary encoding of one pixel: high while the ramp is below the value.
    function automatic logic stream_bit(input logic [WIDTH-1:0] cnt_v,
                                        input logic [WIDTH-1:0] q_v);
        return (cnt_v < q_v);
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic [WIDTH-1:0] q00_r;
    logic [WIDTH-1:0] q01_r;
    logic [WIDTH-1:0] q10_r;
    logic [WIDTH-1:0] q11_r;
    logic             load_s;
    logic             accept_s;
    logic             ready_s;
    logic             active_s;
    logic             last_s;

    assign last_s = (cnt_r == CNT_LAST);

    // Ready: always in IDLE, and on the last enabled bit so frames chain with no gap.
    always_comb begin
        ready_s = 1'b0;
        if (rst) begin
            ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else if ((state_r == ST_RUN) && en && last_s) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid && ready_s;

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                    cnt_s   = CNT_ZERO;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    // Stall: counter and pixels frozen.
                    state_s = ST_RUN;
                    cnt_s   = cnt_r;
                end else if (last_s) begin
                    if (accept_s) begin
                        state_s = ST_RUN;
                        cnt_s   = CNT_ZERO;
                        load_s  = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = CNT_ZERO;
                    end
                end else begin
                    state_s = ST_RUN;
                    cnt_s   = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and pixel registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            q00_r   <= CNT_ZERO;
            q01_r   <= CNT_ZERO;
            q10_r   <= CNT_ZERO;
            q11_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (load_s) begin
                q00_r <= p00;
                q01_r <= p01;
                q10_r <= p10;
                q11_r <= p11;
            end else begin
                q00_r <= q00_r;
                q01_r <= q01_r;
                q10_r <= q10_r;
                q11_r <= q11_r;
            end
        end
    end

    // Bits are only driven in an enabled RUN cycle; reset forces everything low,
    // so a frame aborted by reset never shows its remaining bits or done.
    always_comb begin
        active_s = 1'b0;
        if (rst) begin
            active_s = 1'b0;
        end else begin
            active_s = (state_r == ST_RUN) && en;
        end
    end

    assign in_ready  = ready_s;
    assign bit_valid = active_s;
    assign done      = active_s && last_s;
    assign sel       = active_s && cnt_r[0];
    assign r00       = active_s && stream_bit(cnt_r, q00_r);
    assign r01       = active_s && stream_bit(cnt_r, q01_r);
    assign r10       = active_s && stream_bit(cnt_r, q10_r);
    assign r11       = active_s && stream_bit(cnt_r, q11_r);

endmodule

// File: doc/sc_window_sng.md
# sc_window_sng

Deterministic stochastic number generator for one 2x2 pixel window, directly upstream of the stochastic-computing Roberts-cross edge detector. It accepts four binary pixel values with a valid/ready handshake and emits a 2^WIDTH-cycle frame of unary bitstreams on `r00`..`r11`, plus an exact-0.5 `sel` stream for the scaled adder.
- All four pixel streams share one ramp counter, so they are maximally positively correlated. This is required for XOR to compute |a-b|.
- `sel` is derived from the same counter, so every frame is bit-exact and repeatable.

## Interface
- `WIDTH`, 8, pixel bit width; frame length is N = 2^WIDTH cycles.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `en` in 1: stream enable; 0 stalls the frame in place.
- `in_valid` in 1: pixel window is presented on `p00`..`p11`.
- `in_ready` out 1: block accepts a window this cycle.
- `p00`, `p01`, `p10`, `p11` in WIDTH: unsigned pixel values, sampled on accept.
- `r00`, `r01`, `r10`, `r11` out 1: stochastic bits of the captured pixels.
- `sel` out 1: select stream for the downstream scaled adder, P = 0.5.
- `bit_valid` out 1: the current bits on `r*`/`sel` belong to a frame.
- `done` out 1: high on the final bit cycle of a frame.

## Operation
- Registered state:
  - FSM {IDLE, RUN}.
  - WIDTH-bit counter `cnt`.
  - Four WIDTH-bit pixel registers `q00`..`q11`.
- Accept happens when `in_valid && in_ready` at a rising edge. On accept:
  - `q*` <= `p*`.
  - `cnt` <= 0.
  - State <= RUN.
- `in_ready` = (state==IDLE) || (state==RUN && en && cnt==N-1) — the last-bit cycle accepts, giving back-to-back frames with no gap. `in_ready` is 0 while `rst` is high.
- Outputs in RUN with `en`=1 (combinational from registered state only; no input-to-output path):
  - `rXY` = (`cnt` < `qXY`), unsigned compare.
  - `sel` = `cnt[0]`.
  - `bit_valid` = 1.
  - `done` = (`cnt`==N-1).
- In IDLE, or in RUN with `en`=0: `r*`, `sel`, `bit_valid` and `done` are all 0.
- Counter: in RUN with `en`=1, `cnt` increments each cycle. At `cnt`==N-1:
  - With accept: reload to 0 and stay in RUN.
  - Without accept: go to IDLE, `cnt` <= 0.
- `en`=0 in RUN freezes `cnt` and `q*`. `en` is ignored in IDLE; accept does not require `en`.
- Counts over one frame are exact:
  - Ones on `rXY` = `qXY`; range 0..N-1, so a pixel of N-1 gives N-1 ones and exactly one zero (at `cnt`=N-1).
  - Ones on `sel` = N/2.
  - Ones on `r00^r11` = |`q00`-`q11`|.
- `in_valid` without `in_ready` is ignored. The source must hold `p*` until accepted.
- Reset at any point, including mid-frame:
  - Next state is IDLE, `cnt`=0, `q*`=0.
  - All outputs are 0 during and immediately after reset.
  - The aborted frame is discarded; `done` is never emitted for it.

## Timing
- Accept at edge T; the first frame bit (`cnt`=0) appears in the cycle after T.
- With `en` held high, the frame occupies N consecutive cycles and `done` is high in the Nth.
- Each `en`=0 cycle during RUN extends the frame by one cycle and inserts a `bit_valid`=0 bubble.
- Back-to-back throughput is one window per N enabled cycles. The accept on the `done` cycle makes the next frame's `cnt`=0 bit appear in the very next cycle.
- No latency between `cnt` and outputs. Downstream registers `s` one cycle later as needed.
- Reset values:
  - `in_ready`=0 while `rst` is high, 1 on the first cycle after `rst` deasserts.
  - All other outputs 0.

## Test plan
- Reset: hold `rst` 3 cycles with `in_valid`=1 → no accept. All outputs 0 during reset. `in_ready`=1 on the first cycle after release.
- Single window, WIDTH=8, `p00`=200, `p11`=56, `p01`=90, `p10`=90, `en`=1:
  - First bit one cycle after accept; 256 `bit_valid` cycles; `done` only on the 256th.
  - Ones: `r00`=200, `r11`=56, `r01`=90, `r10`=90, `sel`=128.
  - `r00^r11` ones=144; `r01^r10` ones=0.
- Extremes `p*` = {0, 255, 1, 128}:
  - 0 → zero ones.
  - 255 → 255 ones; the single zero is at the `done` cycle.
  - 1 → only the first bit is 1.
  - 128 → ones in the first 128 bits.
- Back-to-back: `in_valid` held with two windows → second accepted on the first `done` cycle. 512 contiguous `bit_valid` cycles, two `done` pulses 256 cycles apart, per-frame counts exact.
- Stall: `en`=0 for 5 cycles at `cnt`=100 → `bit_valid`=0 and outputs 0 during the stall. `cnt` resumes at 100. Frame spans 261 cycles with unchanged one-counts.
- Reset mid-frame at `cnt`=50 → IDLE, no `done`, outputs 0. The next accepted window produces a full, correct 256-cycle frame.
